// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared cell codes, grid geometry and colour constants for the snake renderer
package snake_pkg;

  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int CELL_PX = 20;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BODY  = 2'd1,
    CELL_HEAD  = 2'd2,
    CELL_FOOD  = 2'd3
  } cell_t;

  // Colours packed as {r[1:0], g[1:0], b[1:0]}
  localparam logic [5:0] RGB_BLACK = 6'b00_00_00;
  localparam logic [5:0] RGB_EMPTY = 6'b00_01_00;
  localparam logic [5:0] RGB_BODY  = 6'b00_11_00;
  localparam logic [5:0] RGB_HEAD  = 6'b11_11_00;
  localparam logic [5:0] RGB_FOOD  = 6'b11_00_00;

  function automatic logic [5:0] cell_rgb(input logic [1:0] c);
    logic [5:0] rgb;
    case (c)
      CELL_EMPTY: rgb = RGB_EMPTY;
      CELL_BODY:  rgb = RGB_BODY;
      CELL_HEAD:  rgb = RGB_HEAD;
      default:    rgb = RGB_FOOD;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/snake_grid_ram.sv
// rtl/snake_grid_ram.sv - occupancy store, one write port and two registered read-before-write read ports
module snake_grid_ram import snake_pkg::*; #(
  parameter int AW    = 10,
  parameter int DEPTH = 768
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [1:0]    i_wdata,
  input  logic [AW-1:0] i_pix_addr,
  output logic [1:0]    o_pix_data,
  input  logic [AW-1:0] i_q_addr,
  output logic [1:0]    o_q_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [1:0] r_mem [DEPTH];
  logic [1:0] r_pix_data;
  logic [1:0] r_q_data;

  // Write and both reads share the edge, so a read of the cell being written sees the old value
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr <= LAST)) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_pix_data <= (i_pix_addr <= LAST) ? r_mem[i_pix_addr] : CELL_EMPTY;
    r_q_data   <= (i_q_addr   <= LAST) ? r_mem[i_q_addr]   : CELL_EMPTY;
  end

  assign o_pix_data = r_pix_data;
  assign o_q_data   = r_q_data;

endmodule

// File: rtl/snake_renderer.sv
// rtl/snake_renderer.sv - VGA pixel stage drawing the snake grid, with clear sweep, query port and frame tick
module snake_renderer #(
  parameter int BIT     = 10,
  parameter int HRES    = 640,
  parameter int VRES    = 480,
  parameter int CELL_PX = snake_pkg::CELL_PX,
  parameter int GRID_W  = snake_pkg::GRID_W,
  parameter int GRID_H  = snake_pkg::GRID_H,
  parameter int CX_W    = 5,
  parameter int CY_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BIT-1:0]  x_pos,
  input  logic [BIT-1:0]  y_pos,
  input  logic            active,
  input  logic            h_sync_in,
  input  logic            v_sync_in,
  input  logic            cell_we,
  input  logic [CX_W-1:0] cell_x,
  input  logic [CY_W-1:0] cell_y,
  input  logic [1:0]      cell_val,
  input  logic [CX_W-1:0] q_x,
  input  logic [CY_W-1:0] q_y,
  output logic [1:0]      q_val,
  output logic            busy,
  output logic            frame_tick,
  output logic [1:0]      r,
  output logic [1:0]      g,
  output logic [1:0]      b,
  output logic            h_sync_out,
  output logic            v_sync_out
);

  import snake_pkg::*;

  localparam int AW    = CX_W + CY_W;
  localparam int CELLS = GRID_W * GRID_H;
  localparam int SUB_W = $clog2(CELL_PX);

  localparam logic [AW-1:0]    LAST_ADDR = AW'(CELLS - 1);
  localparam logic [SUB_W-1:0] LAST_SUB  = SUB_W'(CELL_PX - 1);
  localparam logic [CX_W:0]    GW_LIM    = (CX_W + 1)'(GRID_W);
  localparam logic [CY_W:0]    GH_LIM    = (CY_W + 1)'(GRID_H);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    r_state;
  logic [AW-1:0] r_clr_addr;

  // Column/row counters are one bit wider than the grid index so off-grid pixels can be detected
  logic [SUB_W-1:0] r_sub_x, r_sub_y, w_sub_x_n, w_sub_y_n;
  logic [CX_W:0]    r_col, w_col_n;
  logic [CY_W:0]    r_row, w_row_n;

  logic          r_s1_vis, r_s1_hs, r_s1_vs, r_s1_blank;
  logic [5:0]    r_rgb, w_rgb;
  logic          r_hs2, r_vs2;
  logic          r_frame_tick;
  logic          r_q_ok;

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [1:0]    w_wdata;
  logic          w_cell_ok;
  logic          w_q_ok;
  logic [AW-1:0] w_pix_addr;
  logic [1:0]    w_pix_data;
  logic [1:0]    w_q_data;

  assign busy = (r_state == ST_CLEAR);

  // Clear sweep: one EMPTY write per cycle over the whole store, then hand over to the game logic
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (r_clr_addr == LAST_ADDR) begin
        r_state <= ST_RUN;
      end
    end
  end

  assign w_cell_ok = ({1'b0, cell_x} < GW_LIM) && ({1'b0, cell_y} < GH_LIM);

  // Write port owner: the sweep during CLEAR, game logic (range-checked) during RUN
  always_comb begin
    w_we    = 1'b0;
    w_waddr = {cell_y, cell_x};
    w_wdata = cell_val;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = CELL_EMPTY;
    end else begin
      w_we = cell_we && w_cell_ok;
    end
  end

  // Divider-free cell mapping: counters advance per pixel and per line start
  always_comb begin
    w_sub_x_n = r_sub_x;
    w_col_n   = r_col;
    w_sub_y_n = r_sub_y;
    w_row_n   = r_row;
    if (x_pos == '0) begin
      w_sub_x_n = '0;
      w_col_n   = '0;
      if (y_pos == '0) begin
        w_sub_y_n = '0;
        w_row_n   = '0;
      end else if (r_sub_y == LAST_SUB) begin
        w_sub_y_n = '0;
        w_row_n   = r_row + 1'b1;
      end else begin
        w_sub_y_n = r_sub_y + 1'b1;
      end
    end else if (r_sub_x == LAST_SUB) begin
      w_sub_x_n = '0;
      w_col_n   = r_col + 1'b1;
    end else begin
      w_sub_x_n = r_sub_x + 1'b1;
    end
  end

  // The read is addressed from the next counter values so its data lines up with the S1 registers
  assign w_pix_addr = {w_row_n[CY_W-1:0], w_col_n[CX_W-1:0]};

  snake_grid_ram #(
    .AW    (AW),
    .DEPTH (CELLS)
  ) u_ram (
    .clk        (clk),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_pix_addr (w_pix_addr),
    .o_pix_data (w_pix_data),
    .i_q_addr   ({q_y, q_x}),
    .o_q_data   (w_q_data)
  );

  // S1: counters, visibility, syncs and the blanking flag for the clear sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sub_x    <= '0;
      r_col      <= '0;
      r_sub_y    <= '0;
      r_row      <= '0;
      r_s1_vis   <= 1'b0;
      r_s1_hs    <= 1'b1;
      r_s1_vs    <= 1'b1;
      r_s1_blank <= 1'b1;
    end else begin
      r_sub_x    <= w_sub_x_n;
      r_col      <= w_col_n;
      r_sub_y    <= w_sub_y_n;
      r_row      <= w_row_n;
      r_s1_vis   <= active && (x_pos < BIT'(HRES)) && (y_pos < BIT'(VRES));
      r_s1_hs    <= h_sync_in;
      r_s1_vs    <= v_sync_in;
      r_s1_blank <= busy;
    end
  end

  // S2 colour selection: black outside the visible grid and while the store is being cleared
  always_comb begin
    w_rgb = RGB_BLACK;
    if (!r_s1_blank && r_s1_vis && (r_col < GW_LIM) && (r_row < GH_LIM)) begin
      w_rgb = cell_rgb(w_pix_data);
    end
  end

  // S2 output registers; syncs ride alongside so they stay aligned with RGB
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= RGB_BLACK;
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
    end else begin
      r_rgb <= w_rgb;
      r_hs2 <= r_s1_hs;
      r_vs2 <= r_s1_vs;
    end
  end

  assign r          = r_rgb[5:4];
  assign g          = r_rgb[3:2];
  assign b          = r_rgb[1:0];
  assign h_sync_out = r_hs2;
  assign v_sync_out = r_vs2;

  // Start-of-vblank pulse, taken straight from the inputs rather than the delayed pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= (r_state == ST_RUN) && (x_pos == '0) && (y_pos == BIT'(VRES));
    end
  end

  assign frame_tick = r_frame_tick;

  assign w_q_ok = (r_state == ST_RUN) && ({1'b0, q_x} < GW_LIM) && ({1'b0, q_y} < GH_LIM);

  // Query validity tracks the read issued on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_ok <= 1'b0;
    end else begin
      r_q_ok <= w_q_ok;
    end
  end

  assign q_val = r_q_ok ? w_q_data : 2'b00;

endmodule

// File: tb/tb_snake_renderer.sv
// tb/tb_snake_renderer.sv - directed self-checking bench for snake_renderer
module tb_snake_renderer;

  logic       clk;
  logic       reset;
  logic [9:0] x_pos, y_pos;
  logic       active, h_sync_in, v_sync_in;
  logic       cell_we;
  logic [4:0] cell_x, cell_y, q_x, q_y;
  logic [1:0] cell_val;
  logic [1:0] q_val;
  logic       busy, frame_tick;
  logic [1:0] r, g, b;
  logic       h_sync_out, v_sync_out;

  int n_tests = 0;
  int n_fail  = 0;

  snake_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .active     (active),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .cell_we    (cell_we),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .cell_val   (cell_val),
    .q_x        (q_x),
    .q_y        (q_y),
    .q_val      (q_val),
    .busy       (busy),
    .frame_tick (frame_tick),
    .r          (r),
    .g          (g),
    .b          (b),
    .h_sync_out (h_sync_out),
    .v_sync_out (v_sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input logic act, input logic hs, input logic vs);
    @(negedge clk);
    x_pos     = x[9:0];
    y_pos     = y[9:0];
    active    = act;
    h_sync_in = hs;
    v_sync_in = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int x, input int y, input int v);
    @(negedge clk);
    cell_we  = 1'b1;
    cell_x   = x[4:0];
    cell_y   = y[4:0];
    cell_val = v[1:0];
    @(posedge clk);
    #1;
    cell_we  = 1'b0;
  endtask

  task automatic qchk(input string tag, input int x, input int y, input int exp);
    @(negedge clk);
    q_x = x[4:0];
    q_y = y[4:0];
    @(posedge clk);
    #1;
    chk(tag, int'(q_val), exp);
  endtask

  // Reference colour for a pixel on line 140 (row 7) given cells 5/6/7 hold HEAD/BODY/FOOD
  function automatic int exp_px(input int px);
    case (px / 20)
      5:       return 6'b11_11_00;
      6:       return 6'b00_11_00;
      7:       return 6'b11_00_00;
      default: return 6'b00_01_00;
    endcase
  endfunction

  initial begin
    int cnt, rgb_bad, ft_bad, q_bad;
    int hs_err, vs_err, ticks, tick_x, tick_y;
    logic prev_hs, prev_vs, hs, vs;
    int xs[15];

    reset = 1'b1;
    x_pos = '0; y_pos = '0; active = 1'b0;
    h_sync_in = 1'b0; v_sync_in = 1'b0;
    cell_we = 1'b0; cell_x = '0; cell_y = '0; cell_val = '0;
    q_x = '0; q_y = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 1);
    chk("rst_q_val", int'(q_val), 0);
    chk("rst_rgb", int'({r, g, b}), 0);
    chk("rst_hs_out", int'(h_sync_out), 1);
    chk("rst_vs_out", int'(v_sync_out), 1);
    chk("rst_frame_tick", int'(frame_tick), 0);

    // Sweep with an active pixel on screen and a write attempt that must be ignored
    @(negedge clk);
    reset = 1'b0;
    h_sync_in = 1'b1; v_sync_in = 1'b1;
    active = 1'b1;
    cell_we = 1'b1; cell_x = 5'd2; cell_y = 5'd2; cell_val = 2'd1;
    cnt = 0; rgb_bad = 0; ft_bad = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (busy === 1'b1 && {r, g, b} !== 6'd0) rgb_bad++;
      if (frame_tick !== 1'b0) ft_bad++;
    end
    chk("busy_len", cnt, 768);
    chk("rgb_during_clear", rgb_bad, 0);
    chk("tick_during_clear", ft_bad, 0);
    @(negedge clk);
    cell_we = 1'b0; active = 1'b0;

    q_bad = 0;
    for (int y = 0; y < 24; y++) begin
      for (int x = 0; x < 32; x++) begin
        @(negedge clk);
        q_x = x[4:0]; q_y = y[4:0];
        @(posedge clk);
        #1;
        if (q_val !== 2'd0) q_bad++;
      end
    end
    chk("q_all_empty", q_bad, 0);
    qchk("q_we_in_clear", 2, 2, 0);

    wr(5, 7, 2);
    wr(6, 7, 1);
    wr(7, 7, 3);
    qchk("q_head", 5, 7, 2);
    qchk("q_body", 6, 7, 1);
    qchk("q_food", 7, 7, 3);

    // Walk line starts down to row 7, then paint line 140
    for (int y = 0; y < 140; y++) drive(0, y, 1'b0, 1'b1, 1'b1);
    for (int x = 0; x < 166; x++) begin
      drive(x, 140, 1'b1, 1'b1, 1'b1);
      if (x > 0) chk($sformatf("px_%0d", x - 1), int'({r, g, b}), exp_px(x - 1));
    end

    // Frame with a sparse set of columns per line that still covers every sync edge
    xs = '{0, 1, 2, 638, 639, 640, 641, 655, 656, 657, 750, 751, 752, 798, 799};
    prev_hs = 1'b1; prev_vs = 1'b1;
    hs_err = 0; vs_err = 0; ticks = 0; tick_x = -1; tick_y = -1;
    for (int y = 0; y < 525; y++) begin
      for (int i = 0; i < 15; i++) begin
        hs = !(xs[i] >= 656 && xs[i] < 752);
        vs = !(y >= 490 && y < 492);
        drive(xs[i], y, (xs[i] < 640) && (y < 480), hs, vs);
        if (h_sync_out !== prev_hs) hs_err++;
        if (v_sync_out !== prev_vs) vs_err++;
        if (frame_tick === 1'b1) begin
          ticks++; tick_x = xs[i]; tick_y = y;
        end
        prev_hs = hs; prev_vs = vs;
      end
    end
    chk("hsync_delay_err", hs_err, 0);
    chk("vsync_delay_err", vs_err, 0);
    chk("frame_ticks", ticks, 1);
    chk("tick_x", tick_x, 0);
    chk("tick_y", tick_y, 480);

    // Same-cycle write and query of (3,3)
    @(negedge clk);
    cell_we = 1'b1; cell_x = 5'd3; cell_y = 5'd3; cell_val = 2'd3;
    q_x = 5'd3; q_y = 5'd3;
    @(posedge clk);
    #1;
    chk("rbw_old", int'(q_val), 0);
    cell_we = 1'b0;
    @(posedge clk);
    #1;
    chk("rbw_new", int'(q_val), 3);

    wr(31, 24, 1);
    qchk("oor_w_31_23", 31, 23, 0);
    qchk("oor_w_31_0", 31, 0, 0);
    qchk("oor_query", 31, 24, 0);
    qchk("head_kept", 5, 7, 2);

    // Reset mid-sweep at address 400 restarts a full sweep
    @(negedge clk);
    x_pos = 10'd0; y_pos = 10'd480; active = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    chk("busy_at_400", int'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0; ft_bad = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (frame_tick !== 1'b0) ft_bad++;
    end
    chk("busy_len_restart", cnt, 768);
    chk("tick_suppressed", ft_bad, 0);
    @(negedge clk);
    y_pos = 10'd0;
    qchk("cleared_3_3", 3, 3, 0);
    qchk("cleared_5_7", 5, 7, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
